// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the processor data-memory port.
//               Returns processor read data one cycle after the address and
//               lets a host (loader / bridge) take over the byte-wide RAM
//               through a valid/ready port while the processor is fenced off.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_ni          asynchronous active-low reset
//   addr_i          processor data address
//   dm_wr_i         processor write strobe
//   wr_data_i       processor write data (low DATA_WIDTH bits stored)
//   rd_data_o       processor read data (one cycle latency)
//   host_en_i       host requests memory ownership
//   host_valid_i    host request valid
//   host_wr_i       host request is a write (1) or read (0)
//   host_addr_i     host address
//   host_wdata_i    host write data
//   host_ready_o    host request accepted this cycle
//   host_rvalid_o   one-cycle pulse, host_rdata_o valid
//   host_rdata_o    host read data
//   cpu_busy_o      host owns the memory
//   drop_cnt_o      saturating count of fenced-off processor writes
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [15:0]           addr_i,
  input  logic                  dm_wr_i,
  input  logic [15:0]           wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  host_en_i,
  input  logic                  host_valid_i,
  input  logic                  host_wr_i,
  input  logic [15:0]           host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_ready_o,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  cpu_busy_o,
  output logic [7:0]            drop_cnt_o
);

  localparam int C_DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_SWITCH  = 2'd1,
    ST_HOST    = 2'd2,
    ST_HOST_RD = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [C_DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;
  logic                  host_ready_q;
  logic                  host_rvalid_q;
  logic                  cpu_busy_q;
  logic [7:0]            drop_cnt_q;

  logic                  w_cpu_in;
  logic                  w_host_in;
  logic                  w_host_acc;
  logic [DATA_WIDTH-1:0] w_cpu_rdata;
  logic [DATA_WIDTH-1:0] w_host_rdata;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_unused_bits;

  // Any address bit above the decoded range makes the access out of range.
  assign w_cpu_in  = (addr_i >> DEPTH_LOG2) == 16'd0;
  assign w_host_in = (host_addr_i >> DEPTH_LOG2) == 16'd0;

  // Only the low DATA_WIDTH bits of the processor write bus are stored.
  assign w_unused_bits = ^wr_data_i[15:DATA_WIDTH];

  // host_ready is high exactly in HOST, so acceptance is decided from state.
  assign w_host_acc = (state_q == ST_HOST) && host_valid_i;

  assign w_cpu_rdata  = w_cpu_in  ? mem_q[addr_i[DEPTH_LOG2-1:0]]      : '0;
  assign w_host_rdata = w_host_in ? mem_q[host_addr_i[DEPTH_LOG2-1:0]] : '0;

  // Single write port shared between processor (CPU state) and host (HOST).
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = addr_i[DEPTH_LOG2-1:0];
    w_mem_wdata = wr_data_i[DATA_WIDTH-1:0];
    if (state_q == ST_CPU) begin
      w_mem_we = rst_ni && dm_wr_i && w_cpu_in;
    end else if (w_host_acc && host_wr_i) begin
      w_mem_we    = rst_ni && w_host_in;
      w_mem_waddr = host_addr_i[DEPTH_LOG2-1:0];
      w_mem_wdata = host_wdata_i;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      mem_q[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CPU:     if (host_en_i) state_d = ST_SWITCH;
      ST_SWITCH:  state_d = host_en_i ? ST_HOST : ST_CPU;
      ST_HOST: begin
        // A pending request is always served before ownership returns.
        if (w_host_acc && !host_wr_i) begin
          state_d = ST_HOST_RD;
        end else if (!host_en_i && !host_valid_i) begin
          state_d = ST_CPU;
        end
      end
      ST_HOST_RD: state_d = ST_HOST;
      default:    state_d = ST_CPU;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_CPU;
      rd_data_q     <= '0;
      host_rdata_q  <= '0;
      host_ready_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_busy_q    <= 1'b0;
      drop_cnt_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      host_ready_q  <= (state_d == ST_HOST);
      host_rvalid_q <= (state_d == ST_HOST_RD);
      cpu_busy_q    <= (state_d != ST_CPU);
      // Read-before-write: mem_q still holds the old byte on this edge.
      if (state_q == ST_CPU) begin
        rd_data_q <= w_cpu_rdata;
      end
      if (w_host_acc && !host_wr_i) begin
        host_rdata_q <= w_host_rdata;
      end
      if ((state_q != ST_CPU) && dm_wr_i && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign rd_data_o     = rd_data_q;
  assign host_rdata_o  = host_rdata_q;
  assign host_ready_o  = host_ready_q;
  assign host_rvalid_o = host_rvalid_q;
  assign cpu_busy_o    = cpu_busy_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A byte array model of
//               the RAM plus a dropped-write tally predict every observed
//               output; stimulus mixes directed scenarios and $urandom traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        dm_wr;
  logic [15:0] wr_data;
  logic [7:0]  rd_data;
  logic        host_en;
  logic        host_valid;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ready;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic        cpu_busy;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: known memory bytes and total processor writes dropped.
  logic [7:0] ref_mem [int];
  int         drops;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .DATA_WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .addr_i       (addr),
    .dm_wr_i      (dm_wr),
    .wr_data_i    (wr_data),
    .rd_data_o    (rd_data),
    .host_en_i    (host_en),
    .host_valid_i (host_valid),
    .host_wr_i    (host_wr),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_ready_o (host_ready),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o (host_rdata),
    .cpu_busy_o   (cpu_busy),
    .drop_cnt_o   (drop_cnt)
  );

  function automatic logic [7:0] model_rd(input int a);
    if (a >= 1024) return 8'h00;
    if (!ref_mem.exists(a)) return 8'h00;
    return ref_mem[a];
  endfunction

  function automatic logic [7:0] model_drops();
    return (drops > 255) ? 8'hFF : drops[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic w, input logic [15:0] d);
    addr = a; dm_wr = w; wr_data = d;
    tick();
    dm_wr = 1'b0;
  endtask

  task automatic enter_host();
    host_en = 1'b1; host_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic exit_host();
    host_en = 1'b0; host_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    addr = 16'h0; dm_wr = 1'b0; wr_data = 16'h0;
    host_en = 1'b0; host_valid = 1'b0; host_wr = 1'b0;
    host_addr = 16'h0; host_wdata = 8'h0;
    drops = 0;
    tick();
    tick();
    checks++;
    if ({rd_data, host_rdata, host_ready, host_rvalid, cpu_busy, drop_cnt} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h hrd=%h rdy=%b rv=%b busy=%b drop=%h, want all zero",
               rd_data, host_rdata, host_ready, host_rvalid, cpu_busy, drop_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_rw();
    cpu_cycle(16'h0010, 1'b1, 16'hAB5C);
    ref_mem[16'h10] = 8'h5C;
    cpu_cycle(16'h0010, 1'b0, 16'h0);
    checks++;
    if (rd_data !== 8'h5C) begin
      errors++; $display("FAIL cpu_rw: rd_data=%h want 5c", rd_data);
    end
  endtask

  task automatic test_rbw();
    cpu_cycle(16'h0020, 1'b1, 16'h0011);
    cpu_cycle(16'h0020, 1'b1, 16'h0022);
    checks++;
    if (rd_data !== 8'h11) begin
      errors++; $display("FAIL rbw_old: rd_data=%h want 11", rd_data);
    end
    ref_mem[16'h20] = 8'h22;
    cpu_cycle(16'h0020, 1'b0, 16'h0);
    checks++;
    if (rd_data !== 8'h22) begin
      errors++; $display("FAIL rbw_new: rd_data=%h want 22", rd_data);
    end
  endtask

  task automatic test_handover();
    host_en = 1'b1;
    tick();
    checks++;
    if (cpu_busy !== 1'b1 || host_ready !== 1'b0) begin
      errors++; $display("FAIL handover_switch: busy=%b ready=%b want 1 0", cpu_busy, host_ready);
    end
    tick();
    checks++;
    if (host_ready !== 1'b1 || cpu_busy !== 1'b1) begin
      errors++; $display("FAIL handover_host: ready=%b busy=%b want 1 1", host_ready, cpu_busy);
    end
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_wr = 1'b1;
      host_addr = 16'h0100 + 16'(i); host_wdata = 8'(i + 1);
      ref_mem[16'h100 + i] = 8'(i + 1);
      tick();
      checks++;
      if (host_ready !== 1'b1) begin
        errors++; $display("FAIL host_wr_ready[%0d]: ready=%b want 1", i, host_ready);
      end
    end
    exit_host();
    checks++;
    if (cpu_busy !== 1'b0 || host_ready !== 1'b0) begin
      errors++; $display("FAIL release: busy=%b ready=%b want 0 0", cpu_busy, host_ready);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_cycle(16'h0100 + 16'(i), 1'b0, 16'h0);
      checks++;
      if (rd_data !== 8'(i + 1)) begin
        errors++; $display("FAIL preload_rd[%0d]: rd_data=%h want %h", i, rd_data, 8'(i + 1));
      end
    end
  endtask

  task automatic test_host_dump();
    enter_host();
    host_valid = 1'b1; host_wr = 1'b0; host_addr = 16'h0100;
    tick();
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h01 || host_ready !== 1'b0) begin
      errors++; $display("FAIL dump0: rv=%b rdata=%h rdy=%b want 1 01 0", host_rvalid, host_rdata, host_ready);
    end
    host_addr = 16'h0101;
    tick();
    checks++;
    if (host_rvalid !== 1'b0 || host_ready !== 1'b1) begin
      errors++; $display("FAIL dump_gap: rv=%b rdy=%b want 0 1", host_rvalid, host_ready);
    end
    tick();
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h02 || host_ready !== 1'b0) begin
      errors++; $display("FAIL dump1: rv=%b rdata=%h rdy=%b want 1 02 0", host_rvalid, host_rdata, host_ready);
    end
    host_valid = 1'b0;
    tick();
    checks++;
    if (host_rvalid !== 1'b0) begin
      errors++; $display("FAIL dump_end: rv=%b want 0", host_rvalid);
    end
    exit_host();
  endtask

  task automatic test_fencing();
    enter_host();
    for (int i = 0; i < 3; i++) begin
      addr = 16'h0100; wr_data = 16'h007F; dm_wr = 1'b1;
      drops++;
      tick();
    end
    dm_wr = 1'b0;
    checks++;
    if (drop_cnt !== model_drops()) begin
      errors++; $display("FAIL drop3: drop_cnt=%h want %h", drop_cnt, model_drops());
    end
    exit_host();
    cpu_cycle(16'h0100, 1'b0, 16'h0);
    checks++;
    if (rd_data !== model_rd(16'h100)) begin
      errors++; $display("FAIL fenced_mem: rd_data=%h want %h", rd_data, model_rd(16'h100));
    end
    enter_host();
    for (int i = 0; i < 300; i++) begin
      addr = 16'($urandom_range(0, 1023)); wr_data = 16'($urandom); dm_wr = 1'b1;
      drops++;
      tick();
      if (drops == 255) begin
        checks++;
        if (drop_cnt !== 8'hFF) begin
          errors++; $display("FAIL drop255: drop_cnt=%h want ff", drop_cnt);
        end
      end
    end
    dm_wr = 1'b0;
    checks++;
    if (drop_cnt !== model_drops()) begin
      errors++; $display("FAIL drop_sat: drop_cnt=%h want %h", drop_cnt, model_drops());
    end
    exit_host();
  endtask

  task automatic test_boundary();
    cpu_cycle(16'h0000, 1'b1, 16'h005A);
    ref_mem[0] = 8'h5A;
    cpu_cycle(16'h0001, 1'b1, 16'h00A5);
    ref_mem[1] = 8'hA5;
    cpu_cycle(16'h0400, 1'b1, 16'h00EE);
    cpu_cycle(16'h0000, 1'b0, 16'h0);
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++; $display("FAIL oor_alias: rd_data=%h want 5a", rd_data);
    end
    cpu_cycle(16'h0400, 1'b0, 16'h0);
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL oor_cpu_rd: rd_data=%h want 00", rd_data);
    end
    // Host request without ownership is ignored.
    host_valid = 1'b1; host_wr = 1'b1; host_addr = 16'h0001; host_wdata = 8'h33;
    tick();
    checks++;
    if (host_ready !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++; $display("FAIL cpu_host_ignore: rdy=%b busy=%b want 0 0", host_ready, cpu_busy);
    end
    host_valid = 1'b0;
    enter_host();
    host_valid = 1'b1; host_wr = 1'b1; host_addr = 16'h0401; host_wdata = 8'h77;
    tick();
    host_wr = 1'b0;
    tick();
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h00) begin
      errors++; $display("FAIL oor_host_rd: rv=%b rdata=%h want 1 00", host_rvalid, host_rdata);
    end
    host_valid = 1'b0;
    tick();
    exit_host();
    cpu_cycle(16'h0001, 1'b0, 16'h0);
    checks++;
    if (rd_data !== model_rd(1)) begin
      errors++; $display("FAIL oor_host_alias: rd_data=%h want %h", rd_data, model_rd(1));
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] d;
    logic        w;
    logic [7:0]  exp_rd;
    logic        v;
    logic        dw;
    logic        exp_ready;
    logic        acc;
    logic [7:0]  exp_hrd;
    for (int i = 0; i < 32; i++) begin
      d = 16'($urandom);
      cpu_cycle(16'h0200 + 16'(i), 1'b1, d);
      ref_mem[16'h200 + i] = d[7:0];
    end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0400, 16'hFFFF));
      else                           a = 16'h0200 + 16'($urandom_range(0, 31));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      exp_rd = model_rd(int'(a));
      if (w && a < 16'h0400) ref_mem[int'(a)] = d[7:0];
      cpu_cycle(a, w, d);
      checks++;
      if (rd_data !== exp_rd) begin
        errors++; $display("FAIL rand_cpu[%0d]: addr=%h rd_data=%h want %h", i, a, rd_data, exp_rd);
      end
    end
    enter_host();
    exp_ready = 1'b1;
    exp_hrd   = 8'h00;
    for (int i = 0; i < 120; i++) begin
      v  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 16'h0200 + 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      dw = ($urandom_range(0, 3) == 0);
      host_valid = v; host_wr = w; host_addr = a; host_wdata = d[7:0];
      dm_wr = dw; addr = a; wr_data = ~d;
      acc = exp_ready && v;
      if (acc && w)  ref_mem[int'(a)] = d[7:0];
      if (acc && !w) exp_hrd = model_rd(int'(a));
      if (dw) drops++;
      tick();
      exp_ready = !(acc && !w);
      checks++;
      if (host_ready !== exp_ready || host_rvalid !== (acc && !w) ||
          ((acc && !w) && host_rdata !== exp_hrd) || drop_cnt !== model_drops()) begin
        errors++;
        $display("FAIL rand_host[%0d]: rdy=%b rv=%b rdata=%h drop=%h want %b %b %h %h",
                 i, host_ready, host_rvalid, host_rdata, drop_cnt,
                 exp_ready, (acc && !w), exp_hrd, model_drops());
      end
    end
    dm_wr = 1'b0; host_valid = 1'b0;
    tick();
    exit_host();
    for (int i = 0; i < 32; i++) begin
      cpu_cycle(16'h0200 + 16'(i), 1'b0, 16'h0);
      checks++;
      if (rd_data !== model_rd(16'h200 + i)) begin
        errors++; $display("FAIL rand_final[%0d]: rd_data=%h want %h", i, rd_data, model_rd(16'h200 + i));
      end
    end
  endtask

  task automatic test_reset_midop();
    enter_host();
    host_valid = 1'b1; host_wr = 1'b0; host_addr = 16'h0100;
    tick();
    checks++;
    if (host_rvalid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: rv=%b want 1", host_rvalid);
    end
    host_valid = 1'b0; host_en = 1'b0;
    #2;
    rst_n = 1'b0;
    drops = 0;
    #1;
    checks++;
    if (host_rvalid !== 1'b0 || host_ready !== 1'b0 || cpu_busy !== 1'b0 ||
        drop_cnt !== 8'h00 || rd_data !== 8'h00 || host_rdata !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async: rv=%b rdy=%b busy=%b drop=%h rd=%h hrd=%h want all zero",
               host_rvalid, host_ready, cpu_busy, drop_cnt, rd_data, host_rdata);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cpu_busy !== 1'b0 || host_ready !== 1'b0 || host_rvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: busy=%b rdy=%b rv=%b want 0 0 0", cpu_busy, host_ready, host_rvalid);
    end
    cpu_cycle(16'h0100, 1'b0, 16'h0);
    checks++;
    if (rd_data !== model_rd(16'h100)) begin
      errors++; $display("FAIL midrst_mem0: rd_data=%h want %h", rd_data, model_rd(16'h100));
    end
    cpu_cycle(16'h0010, 1'b0, 16'h0);
    checks++;
    if (rd_data !== model_rd(16'h10)) begin
      errors++; $display("FAIL midrst_mem1: rd_data=%h want %h", rd_data, model_rd(16'h10));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_rw();
    test_rbw();
    test_handover();
    test_host_dump();
    test_fencing();
    test_boundary();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
